spi_packet_master: RTL and testbench
====================================

# spi_packet_master

Master-side SPI transmitter that sends one framed packet, a start byte followed by five payload bytes, to the `spi_slave` receiver. It generates SCLK, SSEL and MOSI from the fabric clock and captures MISO in parallel. It sits between packet-producing logic and the external SPI pins, and is the transmit counterpart of the packet receiver.

## Interface
Parameters:
- `CLK_DIV`, 5: i_clk cycles per SCLK half-period (≥1); 5 gives 1 MHz SCLK from 10 MHz.
- `GAP_CYCLES`, 10: i_clk cycles SSEL stays high between bytes (≥1).
- `START_BYTE`, 8'h11: framing byte sent before the payload.

Ports:
- `i_clk`  in  1: fabric clock (10 MHz nominal).
- `i_rst`  in  1: synchronous, active-high reset.
- `i_start`  in  1: request to send one packet; accepted only when `o_busy`=0.
- `i_packet_data`  in  40: payload; bits [39:32] are sent first.
- `i_MISO`  in  1: serial data from the slave.
- `o_SCLK`  out  1: SPI clock (CPOL=0, CPHA=0).
- `o_SSEL`  out  1: active-low select, asserted per byte.
- `o_MOSI`  out  1: serial data to the slave, MSB first.
- `o_busy`  out  1: frame in progress.
- `o_done`  out  1: one-cycle pulse at end of frame.
- `o_rx_data`  out  40: MISO bits captured during the five payload bytes.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE: SCLK=0, SSEL=1, MOSI=0.
  - On `i_start`=1, latch the 48-bit frame {START_BYTE, i_packet_data}, clear the byte counter (0..5), and go to SHIFT.
- SHIFT:
  - SSEL=0 and MOSI = current frame MSB.
  - The half-period counter counts CLK_DIV cycles.
  - Odd half-periods end with SCLK rising; `i_MISO` is shifted into the receive register at that edge.
  - Even half-periods end with SCLK falling; the frame shifts left one bit, so MOSI changes only after a falling edge.
  - After the 8th falling edge: SSEL=1, MOSI=0.
  - If byte counter <5: increment it and go to GAP. If byte counter =5: pulse `o_done`, load `o_rx_data` with the last 40 captured bits, and go to IDLE.
- GAP: SSEL=1, SCLK=0 for GAP_CYCLES cycles, then back to SHIFT with the next byte's MSB on MOSI.
- `i_start` is ignored while `o_busy`=1. Latched frame data is not affected by `i_packet_data` changes mid-frame.
- Bits received during the start byte are discarded.
- Reset values: SCLK=0, SSEL=1, MOSI=0, busy=0, done=0, rx_data=0, state IDLE.
  - Reset asserted mid-frame forces these values on the next edge. No partial byte completes and `o_done` does not pulse.

## Timing
- Let T be the edge where `i_start` is accepted. From T+1: `o_busy`=1, SSEL=0, MOSI=START_BYTE[7].
- For a byte starting at edge t0:
  - SCLK rises at t0+(2k+1)·CLK_DIV and falls at t0+(2k+2)·CLK_DIV, for k=0..7.
  - SSEL rises at t0+16·CLK_DIV.
- The next byte starts at t0+16·CLK_DIV+GAP_CYCLES.
- `o_done`=1, `o_busy`=0 and `o_rx_data` become valid at T+1+96·CLK_DIV+5·GAP_CYCLES. With defaults this is T+531.
- `o_rx_data` holds until the next `o_done`.
- SCLK duty is exactly 50%. MOSI is stable for CLK_DIV cycles on each side of every rising edge.
- A new `i_start` in the `o_done` cycle is accepted (busy=0 there). The next frame's SSEL falls on the following edge.

## Test plan
- Reset: hold `i_rst` with `i_start`=1 → SCLK=0, SSEL=1, MOSI=0, busy=0, done=0, rx_data=0; no SCLK toggles.
- Nominal: `i_packet_data`=40'h12F100F4F3, `i_start` pulse → a rising-edge sampler decodes bytes 11,12,F1,00,F4,F3, each with its own SSEL-low window; `o_done` at T+531.
- Loopback: `i_MISO` tied to `o_MOSI` → `o_rx_data`=40'h12F100F4F3.
- Busy guard: second `i_start` with 40'hFFFFFFFFFF at T+100 → frame still carries 12F100F4F3, exactly one `o_done`.
- Reset mid-byte: `i_rst` during byte 3 → idle outputs next cycle, no `o_done`. Subsequent start with 40'hA5A5A5A5A5 → full, clean frame.
- Back-to-back with CLK_DIV=1, GAP_CYCLES=1: start in the `o_done` cycle → second frame begins next cycle; each frame lasts 102 cycles.

Source files
------------

// File: rtl/spi_packet_master.sv
// SPI master (CPOL=0, CPHA=0) that sends a start byte and then five payload bytes,
// each byte in its own SSEL-low window, while capturing MISO into o_rx_data.
module spi_packet_master #(
  parameter int          CLK_DIV    = 5,
  parameter int          GAP_CYCLES = 10,
  parameter logic [7:0]  START_BYTE = 8'h11
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [39:0] i_packet_data,
  input  logic        i_MISO,
  output logic        o_SCLK,
  output logic        o_SSEL,
  output logic        o_MOSI,
  output logic        o_busy,
  output logic        o_done,
  output logic [39:0] o_rx_data
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t         state;
  logic [47:0]    frame;
  logic [39:0]    rx_shift;
  logic [HW-1:0]  half_cnt;
  logic [GW-1:0]  gap_cnt;
  logic [2:0]     bit_cnt;
  logic [2:0]     byte_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      frame     <= '0;
      rx_shift  <= '0;
      half_cnt  <= '0;
      gap_cnt   <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      o_SCLK    <= 1'b0;
      o_SSEL    <= 1'b1;
      o_MOSI    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_rx_data <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          o_SCLK <= 1'b0;
          o_SSEL <= 1'b1;
          o_MOSI <= 1'b0;
          if (i_start) begin
            frame    <= {START_BYTE, i_packet_data};
            byte_cnt <= '0;
            bit_cnt  <= '0;
            half_cnt <= '0;
            o_SSEL   <= 1'b0;
            o_MOSI   <= START_BYTE[7];
            o_busy   <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (half_cnt == HW'(CLK_DIV - 1)) begin
            half_cnt <= '0;
            if (!o_SCLK) begin
              o_SCLK   <= 1'b1;
              rx_shift <= {rx_shift[38:0], i_MISO};
            end else begin
              o_SCLK  <= 1'b0;
              frame   <= {frame[46:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                o_SSEL  <= 1'b1;
                o_MOSI  <= 1'b0;
                gap_cnt <= '0;
                if (byte_cnt == 3'd5) begin
                  // 48 bits shifted through a 40-bit register drops the start-byte bits
                  o_done    <= 1'b1;
                  o_busy    <= 1'b0;
                  o_rx_data <= rx_shift;
                  state     <= IDLE;
                end else begin
                  byte_cnt <= byte_cnt + 3'd1;
                  state    <= GAP;
                end
              end else begin
                o_MOSI <= frame[46];
              end
            end
          end else begin
            half_cnt <= half_cnt + HW'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            o_SSEL   <= 1'b0;
            o_MOSI   <= frame[47];
            half_cnt <= '0;
            state    <= SHIFT;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_packet_master.sv
// Randomized bench for spi_packet_master: a bus-level SPI decoder and slave model
// predict the bytes on MOSI, the captured MISO word and the frame timing.
module tb_spi_packet_master;

  localparam int C = 5;
  localparam int G = 10;
  localparam logic [7:0] SB = 8'h11;

  logic        clk = 0;
  logic        rst = 0;
  logic        start = 0;
  logic [39:0] pkt = '0;
  logic        miso;
  logic        sclk, ssel, mosi, busy, done;
  logic [39:0] rx_data;

  logic        b_start = 0;
  logic [39:0] b_pkt = '0;
  logic        b_sclk, b_ssel, b_mosi, b_busy, b_done;
  logic [39:0] b_rx_data;

  logic loop = 0;
  logic miso_drv = 0;
  assign miso = loop ? mosi : miso_drv;

  always #5 clk = ~clk;

  spi_packet_master #(.CLK_DIV(C), .GAP_CYCLES(G), .START_BYTE(SB)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_packet_data(pkt), .i_MISO(miso),
    .o_SCLK(sclk), .o_SSEL(ssel), .o_MOSI(mosi), .o_busy(busy), .o_done(done),
    .o_rx_data(rx_data)
  );

  spi_packet_master #(.CLK_DIV(1), .GAP_CYCLES(1), .START_BYTE(SB)) dut_fast (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_packet_data(b_pkt), .i_MISO(b_mosi),
    .o_SCLK(b_sclk), .o_SSEL(b_ssel), .o_MOSI(b_mosi), .o_busy(b_busy), .o_done(b_done),
    .o_rx_data(b_rx_data)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int rises_total = 0;

  logic [7:0] got_bytes[$];
  int         bitcounts[$];
  logic       rx_bits[$];
  logic [7:0] cur_byte = '0;
  int         cur_bits = 0;
  logic       prev_sclk = 0, prev_ssel = 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Bus-level view: bits on SCLK rising edges, bytes closed by SSEL rising.
  always @(negedge clk) begin
    if (!prev_sclk && sclk === 1'b1) begin
      rises_total++;
      cur_byte = {cur_byte[6:0], mosi};
      cur_bits++;
      rx_bits.push_back(miso);
    end
    if (prev_sclk && sclk === 1'b0) miso_drv = 1'($urandom_range(0, 1));
    if (!prev_ssel && ssel === 1'b1) begin
      got_bytes.push_back(cur_byte);
      bitcounts.push_back(cur_bits);
      cur_bits = 0;
    end
    if (done === 1'b1) done_cnt++;
    prev_sclk = (sclk === 1'b1);
    prev_ssel = (ssel === 1'b1);
  end

  int t_acc;

  task automatic start_frame(input logic [39:0] d);
    @(negedge clk);
    pkt = d;
    start = 1;
    @(negedge clk);
    start = 0;
    t_acc = cyc;
    check_eq("accept_busy", busy, 1);
    check_eq("accept_ssel", ssel, 0);
    check_eq("accept_mosi", mosi, SB[7]);
  endtask

  task automatic wait_done(output int t_done);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    t_done = cyc;
    if (n >= 3000) check_eq("done_timeout", 0, 1);
  endtask

  task automatic run_frame(input logic [39:0] d, input logic lp, input logic poke);
    int d0, t_done;
    logic [47:0] exp_frame;
    logic [39:0] exp_rx;
    loop = lp;
    got_bytes.delete();
    bitcounts.delete();
    rx_bits.delete();
    d0 = done_cnt;
    start_frame(d);
    if (poke) begin
      repeat (99) @(negedge clk);
      pkt = '1;
      start = 1;
      @(negedge clk);
      start = 0;
    end
    wait_done(t_done);
    check_eq("latency", t_done - t_acc, 96 * C + 5 * G);
    repeat (20) @(negedge clk);
    exp_frame = {SB, d};
    check_eq("byte_count", got_bytes.size(), 6);
    for (int i = 0; i < 6 && i < got_bytes.size(); i++) begin
      check_eq($sformatf("byte%0d", i), got_bytes[i], exp_frame[47 - 8 * i -: 8]);
      check_eq($sformatf("bits%0d", i), bitcounts[i], 8);
    end
    check_eq("miso_bits", rx_bits.size(), 48);
    exp_rx = '0;
    for (int i = 8; i < 48 && i < rx_bits.size(); i++) exp_rx = {exp_rx[38:0], rx_bits[i]};
    check_eq("rx_data", rx_data, lp ? d : exp_rx);
    check_eq("done_pulses", done_cnt - d0, 1);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_ssel", ssel, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, n, tb1, td1, td2;
    logic [39:0] d1, d2;

    // Reset held with start requested
    rst = 1;
    start = 1;
    pkt = {$urandom, $urandom};
    repeat (6) @(negedge clk);
    r0 = rises_total;
    repeat (4) @(negedge clk);
    check_eq("rst_sclk", sclk, 0);
    check_eq("rst_ssel", ssel, 1);
    check_eq("rst_mosi", mosi, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rx", rx_data, 0);
    check_eq("rst_no_sclk", rises_total - r0, 0);
    rst = 0;
    start = 0;
    repeat (3) @(negedge clk);

    run_frame(40'h12F100F4F3, 0, 0);
    run_frame(40'h12F100F4F3, 1, 0);
    run_frame(40'h12F100F4F3, 1, 1);

    // Reset in the middle of byte 3
    loop = 0;
    got_bytes.delete();
    start_frame(40'h12F100F4F3);
    n = 0;
    while (got_bytes.size() < 3 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check_eq("midrst_timeout", 0, 1);
    repeat (G + 6 * C) @(negedge clk);
    check_eq("midrst_inbyte", ssel, 0);
    d0 = done_cnt;
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_eq("midrst_sclk", sclk, 0);
    check_eq("midrst_ssel", ssel, 1);
    check_eq("midrst_mosi", mosi, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_rx", rx_data, 0);
    r0 = rises_total;
    repeat (700) @(negedge clk);
    check_eq("midrst_no_done", done_cnt - d0, 0);
    check_eq("midrst_quiet", rises_total - r0, 0);
    run_frame(40'hA5A5A5A5A5, 0, 0);

    for (int k = 0; k < 4; k++) run_frame({$urandom, $urandom}, 1'($urandom_range(0, 1)), 0);

    // Back-to-back frames on the CLK_DIV=1 / GAP_CYCLES=1 instance
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    @(negedge clk);
    b_pkt = d1;
    b_start = 1;
    @(negedge clk);
    b_start = 0;
    tb1 = cyc;
    n = 0;
    while (b_done !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check_eq("b2b_timeout1", 0, 1);
    td1 = cyc;
    check_eq("b2b_latency", td1 - tb1, 101);
    check_eq("b2b_rx1", b_rx_data, d1);
    b_pkt = d2;
    b_start = 1;
    @(negedge clk);
    b_start = 0;
    check_eq("b2b_ssel", b_ssel, 0);
    check_eq("b2b_busy", b_busy, 1);
    check_eq("b2b_rx_hold", b_rx_data, d1);
    n = 0;
    while (b_done !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check_eq("b2b_timeout2", 0, 1);
    td2 = cyc;
    check_eq("b2b_period", td2 - td1, 102);
    check_eq("b2b_rx2", b_rx_data, d2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
